// File: rtl/onehot_dec_pkg.sv
// Shared types and constants for the pipelined one-hot decoder.
// Optional build macro: ONEHOT_DECODER_ACTIVE_LOW_EN selects active-low
// (74x139-style) output words; undefined gives active-high words.
package onehot_dec_pkg;

   localparam int DEF_CODE_W = 2;
   localparam int DEF_CNT_W  = 16;

   // Occupancy of the head + skid buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   // Level of every unselected bit; replicate to OUT_W for the all-inactive word.
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
   localparam logic INACTIVE_LVL = 1'b1;
`else
   localparam logic INACTIVE_LVL = 1'b0;
`endif

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational binary-to-one-hot decode with enable.
// Output polarity follows ONEHOT_DECODER_ACTIVE_LOW_EN via the package.
module onehot_dec_core
   import onehot_dec_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W
) (
   input  logic [CODE_W-1:0]      code,
   input  logic                   en,
   output logic [2**CODE_W-1:0]   word
);

   localparam int OUT_W = 2**CODE_W;

   // Start from the all-inactive word, then flip the selected bit when enabled.
   always_comb begin
      // NOTE: assign a default to every output of a combinational block before
      // any conditional update, otherwise synthesis infers a latch.
      word = {OUT_W{INACTIVE_LVL}};
      if (en) begin
         word[code] = ~INACTIVE_LVL;
      end
   end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Pipelined one-hot decoder: valid/ready input, two-entry head + skid
// buffer, registered one-hot output and a saturating decode-event counter.
// Optional build macro: ONEHOT_DECODER_ACTIVE_LOW_EN (active-low output words).
module onehot_decoder_pipe
   import onehot_dec_pkg::*;
#(
   parameter  int CODE_W = DEF_CODE_W,
   parameter  int CNT_W  = DEF_CNT_W,
   localparam int OUT_W  = 2**CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_onehot,
   output logic [CNT_W-1:0]  dec_count
);

   buf_state_t        state_q, state_d;
   logic              in_ready_q;
   logic [OUT_W-1:0]  head_word_q, skid_word_q;
   logic              head_en_q, skid_en_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [OUT_W-1:0]  dec_word;
   logic              push, pop;
   logic              load_head_in, load_skid_in, shift_skid;

   // Words are decoded once, at acceptance, so the buffer stores final output values.
   onehot_dec_core #(.CODE_W(CODE_W)) u_core (
      .code (in_code),
      .en   (in_en),
      .word (dec_word)
   );

   assign push       = in_valid & in_ready_q;
   assign pop        = out_valid & out_ready;
   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != EMPTY);
   assign out_onehot = head_word_q;
   assign dec_count  = cnt_q;

   // Next buffer state and which register captures the incoming / skid entry.
   always_comb begin
      state_d      = state_q;
      load_head_in = 1'b0;
      load_skid_in = 1'b0;
      shift_skid   = 1'b0;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d      = ONE;
               load_head_in = 1'b1;
            end
         end
         ONE: begin
            case ({push, pop})
               2'b10: begin
                  state_d      = TWO;
                  load_skid_in = 1'b1;
               end
               2'b01: state_d = EMPTY;
               2'b11: load_head_in = 1'b1;
               default: state_d = ONE;
            endcase
         end
         TWO: begin
            if (pop) begin
               state_d    = ONE;
               shift_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Buffer state and registered in_ready (low only when both entries are full).
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   // Head entry: visible on the output, so it resets to the all-inactive word.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_word_q <= {OUT_W{INACTIVE_LVL}};
         head_en_q   <= 1'b0;
      end else if (load_head_in) begin
         head_word_q <= dec_word;
         head_en_q   <= in_en;
      end else if (shift_skid) begin
         head_word_q <= skid_word_q;
         head_en_q   <= skid_en_q;
      end
   end

   // Skid entry: only read when state is TWO.
   always_ff @(posedge clk) begin
      // NOTE: storage qualified by the state register needs no reset; clearing
      // the state alone discards its contents.
      if (load_skid_in) begin
         skid_word_q <= dec_word;
         skid_en_q   <= in_en;
      end
   end

   // Count delivered enabled words, holding at the all-ones maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (pop && head_en_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Scoreboard bench for onehot_decoder_pipe (CNT_W=4 so saturation is reachable).
// Honours ONEHOT_DECODER_ACTIVE_LOW_EN for expected word polarity.
module tb_onehot_decoder_pipe;

   localparam int CODE_W = 2;
   localparam int CNT_W  = 4;
   localparam int OUT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

   typedef struct {
      logic [OUT_W-1:0] word;
      logic             en;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;
   logic              in_en;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_onehot;
   logic [CNT_W-1:0]  dec_count;

   entry_t            sb_q[$];
   logic [CNT_W-1:0]  exp_count;
   int                errors = 0;
   int                checks = 0;

   onehot_decoder_pipe #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_en      (in_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .dec_count  (dec_count)
   );

   always #5 clk = ~clk;

   function automatic logic [OUT_W-1:0] exp_word(input logic [CODE_W-1:0] c, input logic e);
      logic [OUT_W-1:0] w;
      w = e ? (4'b0001 << c) : 4'b0000;
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
      w = ~w;
`endif
      return w;
   endfunction

   task automatic drive(input logic v, input logic [CODE_W-1:0] c, input logic e, input logic ordy);
      in_valid  = v;
      in_code   = c;
      in_en     = e;
      out_ready = ordy;
   endtask

   // One clock: compare outputs against the model mid-cycle, then update the
   // model from the handshakes seen just before the rising edge.
   task automatic tick();
      entry_t e;
      logic   do_push, do_pop;
      @(negedge clk);
      checks++;
      if (out_valid !== (sb_q.size() != 0)) begin
         errors++;
         $display("FAIL out_valid: got %b want %b", out_valid, sb_q.size() != 0);
      end
      checks++;
      if (in_ready !== (sb_q.size() < 2)) begin
         errors++;
         $display("FAIL in_ready: got %b want %b", in_ready, sb_q.size() < 2);
      end
      checks++;
      if (dec_count !== exp_count) begin
         errors++;
         $display("FAIL dec_count: got %0d want %0d", dec_count, exp_count);
      end
      if (sb_q.size() != 0) begin
         checks++;
         if (out_onehot !== sb_q[0].word) begin
            errors++;
            $display("FAIL out_onehot: got %b want %b", out_onehot, sb_q[0].word);
         end
      end
      do_push = in_valid && (sb_q.size() < 2);
      do_pop  = out_ready && (sb_q.size() != 0);
      if (rst) begin
         sb_q.delete();
         exp_count = '0;
      end else begin
         if (do_pop) begin
            e = sb_q.pop_front();
            if (e.en && exp_count != CNT_MAX) exp_count = exp_count + 1'b1;
         end
         if (do_push) begin
            e.word = exp_word(in_code, in_en);
            e.en   = in_en;
            sb_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      drive(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         if (sb_q.size() == 0) break;
         tick();
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d words outstanding, want 0", sb_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      sb_q.delete();
      exp_count = '0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if (out_onehot !== exp_word('0, 1'b0)) begin
         errors++;
         $display("FAIL reset_onehot: got %b want %b", out_onehot, exp_word('0, 1'b0));
      end
      checks++;
      if (dec_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", dec_count); end
      rst = 1'b0;
   endtask

   task automatic test_sequence();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, CODE_W'(c), 1'b1, 1'b1);
         tick();
         // Accepted at the last edge, so the word must already be at the output.
         checks++;
         if (out_valid !== 1'b1 || out_onehot !== exp_word(CODE_W'(c), 1'b1)) begin
            errors++;
            $display("FAIL latency_code%0d: got v=%b %b want v=1 %b", c, out_valid, out_onehot,
                     exp_word(CODE_W'(c), 1'b1));
         end
      end
      drain();
      checks++;
      if (dec_count !== 4'd4) begin errors++; $display("FAIL seq_count: got %0d want 4", dec_count); end
   endtask

   task automatic test_disabled();
      drive(1'b1, 2'd2, 1'b0, 1'b1);
      tick();
      checks++;
      if (out_onehot !== exp_word(2'd2, 1'b0)) begin
         errors++;
         $display("FAIL disabled_word: got %b want %b", out_onehot, exp_word(2'd2, 1'b0));
      end
      drain();
      checks++;
      if (dec_count !== 4'd4) begin errors++; $display("FAIL disabled_count: got %0d want 4", dec_count); end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 2'd1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'd3, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      repeat (3) tick();
      checks++;
      if (out_onehot !== exp_word(2'd1, 1'b1)) begin
         errors++;
         $display("FAIL bp_hold: got %b want %b", out_onehot, exp_word(2'd1, 1'b1));
      end
      drain();
      checks++;
      if (dec_count !== 4'd6) begin errors++; $display("FAIL bp_count: got %0d want 6", dec_count); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 1'b1);
         tick();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got rdy=%b v=%b want rdy=1 v=1", i, in_ready, out_valid);
         end
      end
      drain();
      checks++;
      if (dec_count !== CNT_MAX) begin errors++; $display("FAIL b2b_count: got %0d want 15", dec_count); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 2'd0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'd2, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || dec_count !== '0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0",
                  out_valid, in_ready, dec_count);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      repeat (4) tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, CODE_W'(i % 4), 1'b1, 1'b1);
         tick();
      end
      drain();
      checks++;
      if (dec_count !== CNT_MAX) begin errors++; $display("FAIL sat_count: got %0d want 15", dec_count); end
   endtask

   initial begin
      exp_count = '0;
      test_reset();
      test_sequence();
      test_disabled();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
Pipelined binary-to-one-hot decoder with enable, the decode-side counterpart of the team's priority/binary encoders. It accepts a CODE_W-bit code and enable over a valid/ready handshake. It buffers up to two codes in a skid register and presents a registered one-hot word downstream. It sits between a code-producing stage, such as an encoder output or a register-select field, and a consumer that applies backpressure.

Parameters:
- CODE_W, 2, width of the binary input code.
- OUT_W, 2**CODE_W, one-hot output width. Derived localparam; not overridable.
- CNT_W, 16, width of the saturating decode-event counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input code present.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  CODE_W  binary code to decode.
- in_en  input  1  decoder enable. 0 gives an all-inactive output word.
- out_valid  output  1  out_onehot holds a decoded word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_onehot  output  OUT_W  decoded word: bit[in_code] active when enabled.
- dec_count  output  CNT_W  number of enabled words delivered; saturating.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - State goes to EMPTY; out_valid=0; in_ready=1.
  - out_onehot = all-inactive: 0s, or 1s with the optional feature.
  - dec_count=0.
  - Any buffered entries are discarded. Reset mid-transfer drops them silently, with no partial output.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Decode: each entry stores a decoded word, computed at input time.
  - in_en=1: word = 1 << in_code.
  - in_en=0: word = all-inactive.
  - The stored word carries one en flag per entry.
- Latency: a code accepted at edge N appears on out_onehot with out_valid=1 after edge N (one cycle) when the buffer was EMPTY.
- Buffer FSM. States: EMPTY, ONE (head register valid), TWO (head + skid valid).
  - EMPTY: push goes to ONE.
  - ONE:
    - push & !pop goes to TWO; the new entry goes to skid.
    - pop & !push goes to EMPTY.
    - push & pop stays in ONE; the new entry goes to head.
  - TWO: pop goes to ONE; skid moves to head. Push is impossible because in_ready=0.
- in_ready: registered. It is 1 in EMPTY and ONE, 0 in TWO. It never depends combinationally on out_ready.
- out_valid = (state != EMPTY). out_onehot always reflects the head entry.
- Ordering: strict FIFO. No entry is dropped or duplicated under any valid/ready pattern.
- Stability: while out_valid=1 & out_ready=0, out_onehot and out_valid hold.
- dec_count: increments by 1 on each output transfer whose entry had en=1. It holds at 2**CNT_W-1 once reached; no wrap.
- in_valid=0: in_code and in_en are don't-care; state is unaffected.

Optional Feature:
- Macro: ONEHOT_DECODER_ACTIVE_LOW_EN.
- Defined:
  - out_onehot is active-low, 74x139 style: the selected bit is 0 and all others are 1.
  - The all-inactive word (reset, in_en=0) is all 1s.
- Undefined: active-high as above. The all-inactive word is all 0s.
- Handshake, latency and dec_count are identical in both builds. Inversion is applied at the decode point only.

Decomposition:
- Package onehot_dec_pkg holds:
  - The buffer-state enum (EMPTY/ONE/TWO).
  - Default CODE_W and CNT_W constants.
  - An inactive-word constant selected by the macro.
- Sub-module onehot_dec_core: purely combinational decode of (code, en) to an OUT_W word, including the polarity option. Instantiated once at the input side.

Test Plan:
- Reset, then push codes 0,1,2,3 with en=1 and out_ready=1 held → out_onehot sequence 0001, 0010, 0100, 1000, each one cycle after acceptance; dec_count=4.
- Push code 2 with en=0 → out_onehot=0000 (1111 with macro); dec_count unchanged.
- Hold out_ready=0 and push codes 1 then 3 → in_ready drops to 0 after the 2nd accept; out_onehot holds 0010. Release out_ready → 0010 then 1000 delivered in order, no loss.
- Assert in_valid and out_ready continuously with alternating codes → one word per cycle; state stays ONE; in_ready stays 1.
- Fill to TWO, assert rst for one cycle → next cycle out_valid=0, in_ready=1, dec_count=0; neither buffered word ever appears.
- Force dec_count near max (CNT_W=4 build) and deliver 20 enabled words → dec_count stops at 15.
